// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALU command codes and FSM state encodings.
package alu_issue_ctrl_pkg;

   localparam int unsigned CmdW   = 3;
   localparam int unsigned TimerW = 8;

   typedef enum logic [CmdW-1:0] {
      CmdAdd  = 3'd0,
      CmdSub  = 3'd1,
      CmdXor  = 3'd2,
      CmdSlt  = 3'd3,
      CmdAnd  = 3'd4,
      CmdNand = 3'd5,
      CmdNor  = 3'd6,
      CmdOr   = 3'd7
   } alu_cmd_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StResp   = 2'd2
   } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response signals of the ALU issue controller.
// slave: the controller itself; master: the surrounding datapath plus the combinational ALU.
interface alu_issue_ctrl_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned COUNT_W = 16
) ();

   logic               req_valid;
   logic               req_ready;
   logic [WIDTH-1:0]   req_a;
   logic [WIDTH-1:0]   req_b;
   logic [2:0]         req_cmd;

   logic [WIDTH-1:0]   alu_operandA;
   logic [WIDTH-1:0]   alu_operandB;
   logic [2:0]         alu_command;
   logic [WIDTH-1:0]   alu_result;
   logic               alu_carryout;
   logic               alu_zero;
   logic               alu_overflow;

   logic               rsp_valid;
   logic               rsp_ready;
   logic [WIDTH-1:0]   rsp_result;
   logic               rsp_carryout;
   logic               rsp_zero;
   logic               rsp_overflow;
   logic               rsp_mismatch;
   logic [COUNT_W-1:0] ops_done;

   modport slave (
      input  req_valid, req_a, req_b, req_cmd,
      input  alu_result, alu_carryout, alu_zero, alu_overflow,
      input  rsp_ready,
      output req_ready,
      output alu_operandA, alu_operandB, alu_command,
      output rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, rsp_mismatch,
      output ops_done
   );

   modport master (
      output req_valid, req_a, req_b, req_cmd,
      output alu_result, alu_carryout, alu_zero, alu_overflow,
      output rsp_ready,
      input  req_ready,
      input  alu_operandA, alu_operandB, alu_command,
      input  rsp_valid, rsp_result, rsp_carryout, rsp_zero, rsp_overflow, rsp_mismatch,
      input  ops_done
   );

endinterface

// File: rtl/alu_settle_timer.sv
// Down-counter timing the ALU ripple settle interval; done_o is high once the count reaches zero.
module alu_settle_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             done_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Clocked, handshaked front end for the combinational 32-bit ALU: launch, settle, capture, respond.
// Optional ALU_CHECK_EN adds a reference model that flags result/zero disagreement at capture.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned COUNT_W       = 16
) (
   input logic             clk,
   input logic             reset,
   alu_issue_ctrl_if.slave bus
);

   // Counter starts at SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES edges after acceptance.
   localparam logic [TimerW-1:0] SettleLoad = TimerW'(SETTLE_CYCLES - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q;
   alu_cmd_e           cmd_q;
   logic [WIDTH-1:0]   res_q;
   logic               cy_q, z_q, ov_q;
   logic [COUNT_W-1:0] ops_q, ops_d;
   logic               load, capture, timer_done;

   alu_settle_timer #(
      .Width (TimerW)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load),
      .load_val_i (SettleLoad),
      .done_o     (timer_done)
   );

   always_comb begin
      state_d = state_q;
      ops_d   = ops_q;
      load    = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               load    = 1'b1;
               state_d = StSettle;
            end
         end
         StSettle: begin
            if (timer_done) begin
               capture = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               ops_d   = ops_q + 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         cmd_q   <= CmdAdd;
         res_q   <= '0;
         cy_q    <= 1'b0;
         z_q     <= 1'b0;
         ov_q    <= 1'b0;
         ops_q   <= '0;
      end else begin
         state_q <= state_d;
         ops_q   <= ops_d;
         if (load) begin
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            cmd_q <= alu_cmd_e'(bus.req_cmd);
         end
         if (capture) begin
            res_q <= bus.alu_result;
            cy_q  <= bus.alu_carryout;
            z_q   <= bus.alu_zero;
            ov_q  <= bus.alu_overflow;
         end
      end
   end

`ifdef ALU_CHECK_EN
   logic [WIDTH-1:0] exp_res;
   logic             mis_q;

   always_comb begin
      exp_res = '0;
      unique case (cmd_q)
         CmdAdd:  exp_res = a_q + b_q;
         CmdSub:  exp_res = a_q - b_q;
         CmdXor:  exp_res = a_q ^ b_q;
         CmdSlt:  exp_res = WIDTH'($signed(a_q) < $signed(b_q));
         CmdAnd:  exp_res = a_q & b_q;
         CmdNand: exp_res = ~(a_q & b_q);
         CmdNor:  exp_res = ~(a_q | b_q);
         CmdOr:   exp_res = a_q | b_q;
         default: exp_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mis_q <= 1'b0;
      end else if (capture) begin
         mis_q <= (exp_res != bus.alu_result) || ((exp_res == '0) != bus.alu_zero);
      end
   end

   assign bus.rsp_mismatch = mis_q;
`else
   assign bus.rsp_mismatch = 1'b0;
`endif

   assign bus.req_ready    = (state_q == StIdle);
   assign bus.rsp_valid    = (state_q == StResp);
   assign bus.alu_operandA = a_q;
   assign bus.alu_operandB = b_q;
   assign bus.alu_command  = cmd_q;
   assign bus.rsp_result   = res_q;
   assign bus.rsp_carryout = cy_q;
   assign bus.rsp_zero     = z_q;
   assign bus.rsp_overflow = ov_q;
   assign bus.ops_done     = ops_q;

endmodule
